// File: rtl/io_bus_responder.sv
// rtl/io_bus_responder.sv - memory-mapped I/O slave for switches, button, LEDs and seven-segment scan
// Optional error status register and io_err flag enabled by IO_ERR_STATUS_EN.
module io_bus_responder #(
  parameter int          SW_W            = 16,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
  parameter logic [16:0] SCAN_DIV        = 17'd100_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            io_read,
  input  logic            io_write,
  input  logic [9:0]      addr_low,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            rd_valid,
  input  logic [SW_W-1:0] sw,
  input  logic            btn,
  output logic [SW_W-1:0] led,
  output logic [7:0]      seg_an,
  output logic [7:0]      seg_cat,
  output logic            io_err
);

  logic [7:0]      word;
  logic            unused_bits;
  logic [SW_W-1:0] sw_s1, sw_s2;
  logic            btn_s1, btn_s2, btn_deb, btn_sticky;
  logic [19:0]     deb_cnt;
  logic            deb_done, deb_rise;
  logic [31:0]     seg_data;
  logic [7:0]      seg_mask;
  logic [16:0]     scan_cnt;
  logic [2:0]      digit;
  logic [31:0]     rd_mux;
  logic            err_q;

  assign word        = addr_low[9:2];
  assign unused_bits = ^addr_low[1:0];

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
    endcase
  endfunction

  // Debounced level flips once the synced input has disagreed for DEBOUNCE_CYCLES edges
  assign deb_done = (btn_s2 != btn_deb) && (deb_cnt == DEBOUNCE_CYCLES - 20'd1);
  assign deb_rise = deb_done && btn_s2;

  always_comb begin
    rd_mux = 32'd0;
    case (word)
      8'h00: rd_mux = 32'(sw_s2);
      8'h01: rd_mux = {31'd0, btn_sticky};
`ifdef IO_ERR_STATUS_EN
      8'h02: rd_mux = {31'd0, err_q};
`endif
      8'h04: rd_mux = 32'(led);
      8'h08: rd_mux = seg_data;
      8'h09: rd_mux = {24'd0, seg_mask};
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1 <= '0;  sw_s2 <= '0;
      btn_s1 <= 1'b0;  btn_s2 <= 1'b0;
      btn_deb <= 1'b0;  deb_cnt <= 20'd0;  btn_sticky <= 1'b0;
      led <= '0;  seg_data <= 32'd0;  seg_mask <= 8'd0;
      rdata <= 32'd0;  rd_valid <= 1'b0;
      scan_cnt <= 17'd0;  digit <= 3'd0;
      seg_an <= 8'hFF;  seg_cat <= 8'hFF;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      if (btn_s2 == btn_deb) begin
        deb_cnt <= 20'd0;
      end else if (deb_done) begin
        deb_cnt <= 20'd0;
        btn_deb <= btn_s2;
      end else begin
        deb_cnt <= deb_cnt + 20'd1;
      end
      if (deb_rise) btn_sticky <= 1'b1;
      else if (io_read && word == 8'h01) btn_sticky <= 1'b0;

      rd_valid <= io_read;
      if (io_read) rdata <= rd_mux;
      if (io_write) begin
        case (word)
          8'h04: led      <= wdata[SW_W-1:0];
          8'h08: seg_data <= wdata;
          8'h09: seg_mask <= wdata[7:0];
          default: ;
        endcase
      end

      if (scan_cnt == SCAN_DIV - 17'd1) begin
        scan_cnt <= 17'd0;
        digit    <= digit + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 17'd1;
      end
      seg_an  <= seg_mask[digit] ? ~(8'd1 << digit) : 8'hFF;
      seg_cat <= hex7(seg_data[{digit, 2'b00} +: 4]);
    end
  end

`ifdef IO_ERR_STATUS_EN
  logic mapped, err_hit;
  assign mapped  = (word == 8'h00) || (word == 8'h01) || (word == 8'h02) ||
                   (word == 8'h04) || (word == 8'h08) || (word == 8'h09);
  assign err_hit = ((io_read || io_write) && !mapped) ||
                   (io_write && (word == 8'h00 || word == 8'h01));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (err_hit) err_q <= 1'b1;
    else if (io_read && word == 8'h02) err_q <= 1'b0;
  end
`else
  assign err_q = 1'b0;
`endif

  assign io_err = err_q;

endmodule

// File: tb/tb_io_bus_responder.sv
// tb/tb_io_bus_responder.sv - self-checking bench for io_bus_responder
// Expectations follow IO_ERR_STATUS_EN when it is defined for the build.
module tb_io_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_read = 1'b0, io_write = 1'b0;
  logic [9:0]  addr_low = 10'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        rd_valid;
  logic [15:0] sw = 16'd0;
  logic        btn = 1'b0;
  logic [15:0] led;
  logic [7:0]  seg_an, seg_cat;
  logic        io_err;

  int n_checks = 0;
  int n_fail = 0;
  int edge_cnt = 0;

  logic [15:0] m_sw = 16'd0, m_led = 16'd0;
  logic [31:0] m_seg_data = 32'd0, m_rdata = 32'd0;
  logic [7:0]  m_seg_mask = 8'd0;
  logic        m_sticky = 1'b0, m_err = 1'b0;

  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [9:0] pool [10] = '{10'h000, 10'h004, 10'h008, 10'h010, 10'h020,
                            10'h024, 10'h00C, 10'h014, 10'h3FC, 10'h100};

  io_bus_responder #(.SW_W(16), .DEBOUNCE_CYCLES(20'd8), .SCAN_DIV(17'd4)) dut (
    .clk(clk), .rst_n(rst_n), .io_read(io_read), .io_write(io_write),
    .addr_low(addr_low), .wdata(wdata), .rdata(rdata), .rd_valid(rd_valid),
    .sw(sw), .btn(btn), .led(led), .seg_an(seg_an), .seg_cat(seg_cat), .io_err(io_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else edge_cnt <= edge_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [9:0] a);
    case (a >> 2)
      0: return {16'd0, m_sw};
      1: return {31'd0, m_sticky};
`ifdef IO_ERR_STATUS_EN
      2: return {31'd0, m_err};
`endif
      4: return {16'd0, m_led};
      8: return m_seg_data;
      9: return {24'd0, m_seg_mask};
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_mapped(input logic [9:0] a);
    int w = int'(a >> 2);
    return w == 0 || w == 1 || w == 2 || w == 4 || w == 8 || w == 9;
  endfunction

  task automatic access(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d);
    logic [31:0] exp_r;
    logic        new_err;
    exp_r = model_read(a);
    @(negedge clk);
    io_read = rd; io_write = wr; addr_low = a; wdata = d;
    @(negedge clk);
    io_read = 1'b0; io_write = 1'b0;
    if (wr) begin
      if ((a >> 2) == 4) m_led = d[15:0];
      if ((a >> 2) == 8) m_seg_data = d;
      if ((a >> 2) == 9) m_seg_mask = d[7:0];
    end
`ifdef IO_ERR_STATUS_EN
    new_err = ((rd || wr) && !is_mapped(a)) || (wr && (a >> 2) < 2);
    if (rd && (a >> 2) == 2) m_err = new_err;
    else m_err = m_err | new_err;
`else
    new_err = 1'b0;
    m_err = new_err;
`endif
    if (rd && (a >> 2) == 1) m_sticky = 1'b0;
    if (rd) m_rdata = exp_r;
    chk("rdata", rdata, m_rdata);
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, rd});
    chk("led", {16'd0, led}, {16'd0, m_led});
    chk("io_err", {31'd0, io_err}, {31'd0, m_err});
  endtask

  initial begin
    int d;
    logic [9:0] a;
    int op;
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_led", {16'd0, led}, 32'd0);
    chk("rst_seg_an", {24'd0, seg_an}, 32'hFF);
    chk("rst_seg_cat", {24'd0, seg_cat}, 32'hFF);
    chk("rst_io_err", {31'd0, io_err}, 32'd0);
    rst_n = 1'b1;

    access(1'b0, 1'b1, 10'h010, 32'h0000_A5A5);
    chk("led_a5a5", {16'd0, led}, 32'h0000_A5A5);
    access(1'b1, 1'b0, 10'h010, 32'd0);
    @(negedge clk);
    chk("rd_valid_single", {31'd0, rd_valid}, 32'd0);

    sw = 16'h1234; m_sw = 16'h1234;
    repeat (3) @(negedge clk);
    access(1'b1, 1'b0, 10'h000, 32'd0);
    chk("sw_read", rdata, 32'h0000_1234);
    @(negedge clk);
    chk("sw_rd_valid_drop", {31'd0, rd_valid}, 32'd0);

    btn = 1'b1;
    repeat (5) @(negedge clk);
    btn = 1'b0;
    repeat (12) @(negedge clk);
    access(1'b1, 1'b0, 10'h004, 32'd0);
    btn = 1'b1;
    repeat (12) @(negedge clk);
    m_sticky = 1'b1;
    access(1'b1, 1'b0, 10'h004, 32'd0);
    access(1'b1, 1'b0, 10'h004, 32'd0);
    btn = 1'b0;
    repeat (15) @(negedge clk);
    access(1'b1, 1'b0, 10'h004, 32'd0);

    access(1'b0, 1'b1, 10'h020, 32'h7654_3210);
    access(1'b0, 1'b1, 10'h024, 32'h0000_0005);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      d = ((edge_cnt - 1) / 4) % 8;
      chk("seg_an", {24'd0, seg_an}, {24'd0, m_seg_mask[d] ? ~(8'd1 << d) : 8'hFF});
      chk("seg_cat", {24'd0, seg_cat}, {24'd0, seg_tbl[(m_seg_data >> (4 * d)) & 32'hF]});
      @(negedge clk);
    end

    access(1'b0, 1'b1, 10'h010, 32'h0000_0001);
    access(1'b1, 1'b1, 10'h010, 32'h0000_00FF);
    chk("rw_same_rdata", rdata, 32'h0000_0001);
    chk("rw_same_led", {16'd0, led}, 32'h0000_00FF);

    access(1'b0, 1'b1, 10'h000, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 10'h008, 32'd0);
`ifdef IO_ERR_STATUS_EN
    chk("err_read", rdata, 32'd1);
`else
    chk("err_read", rdata, 32'd0);
`endif
    chk("err_cleared", {31'd0, io_err}, 32'd0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        sw = 16'($urandom);
        m_sw = sw;
        repeat (3) @(negedge clk);
      end
      a = pool[$urandom_range(0, 9)] | 10'($urandom_range(0, 3));
      op = $urandom_range(0, 3);
      access(op != 1, op == 1 || op == 2, a, $urandom);
    end

    access(1'b0, 1'b1, 10'h010, 32'h0000_BEEF);
    @(negedge clk);
    io_read = 1'b1; addr_low = 10'h010;
    @(posedge clk);
    #1;
    chk("pre_reset_rd_valid", {31'd0, rd_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    io_read = 1'b0;
    chk("mid_reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("mid_reset_rdata", rdata, 32'd0);
    chk("mid_reset_led", {16'd0, led}, 32'd0);
    chk("mid_reset_seg_an", {24'd0, seg_an}, 32'hFF);
    m_led = 16'd0; m_seg_data = 32'd0; m_seg_mask = 8'd0; m_rdata = 32'd0;
    m_sticky = 1'b0; m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    access(1'b1, 1'b0, 10'h024, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
